pipe_ctrl: RTL

Pipeline hold/redirect controller that drives the `hold_flag` bus and the fetch redirect consumed by the pc, if_id and id_ex stage registers. It collects four inputs from execute and the instruction bus:
- jump requests,
- multi-cycle execute stalls,
- fetch-bus waits,
- (implicitly) a bus watchdog.

It sequences them through a small state machine into registered hold levels and a one-cycle jump pulse. A bus watchdog releases a stuck fetch stall and reports a timeout.

---
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hold/redirect controller: arbitrates jump, execute-stall and fetch-bus
// stall requests into registered cumulative hold levels and a one-cycle redirect.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_jump_req,
    input  logic [31:0] ex_jump_addr,
    input  logic        ex_hold_req,
    input  logic        bus_hold_req,
    output logic [2:0]  hold_flag,
    output logic        jump_flag,
    output logic [31:0] jump_addr,
    output logic        bus_timeout
);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_ID   = 3'b111;

    localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic [7:0]  bus_cnt, bus_cnt_nxt;
    logic [2:0]  hold_nxt;
    logic        jump_flag_nxt;
    logic [31:0] jump_addr_nxt;
    logic        timeout_nxt;
    logic        evaluate;
    logic        jump_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            flush_cnt   <= 4'd0;
            bus_cnt     <= 8'd0;
            hold_flag   <= HOLD_NONE;
            jump_flag   <= 1'b0;
            jump_addr   <= 32'h0;
            bus_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            bus_cnt     <= bus_cnt_nxt;
            hold_flag   <= hold_nxt;
            jump_flag   <= jump_flag_nxt;
            jump_addr   <= jump_addr_nxt;
            bus_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        bus_cnt_nxt   = bus_cnt;
        hold_nxt      = HOLD_NONE;
        jump_flag_nxt = 1'b0;
        jump_addr_nxt = jump_addr;
        timeout_nxt   = 1'b0;
        evaluate      = 1'b0;
        jump_ok       = 1'b0;

        case (state)
            RUN, STALL: begin
                evaluate = 1'b1;
                jump_ok  = 1'b1;
            end
            FLUSH: begin
                // Execute is bubbled throughout the flush, so any jump seen here is stale.
                if (flush_cnt != 4'd0) begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                    hold_nxt      = HOLD_ID;
                end else begin
                    evaluate = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (evaluate) begin
            if (jump_ok && ex_jump_req) begin
                jump_flag_nxt = 1'b1;
                jump_addr_nxt = ex_jump_addr;
                hold_nxt      = HOLD_ID;
                flush_cnt_nxt = FLUSH_INIT;
                bus_cnt_nxt   = 8'd0;
                state_nxt     = FLUSH;
            end else if (ex_hold_req) begin
                hold_nxt    = HOLD_ID;
                bus_cnt_nxt = 8'd0;
                state_nxt   = STALL;
            end else if (bus_hold_req) begin
                // Watchdog: let the pipeline advance one cycle, then re-arm from zero.
                if (bus_cnt == TIMEOUT_CNT) begin
                    timeout_nxt = 1'b1;
                    hold_nxt    = HOLD_NONE;
                    bus_cnt_nxt = 8'd0;
                    state_nxt   = RUN;
                end else begin
                    hold_nxt    = HOLD_PC;
                    bus_cnt_nxt = bus_cnt + 8'd1;
                    state_nxt   = STALL;
                end
            end else begin
                hold_nxt    = HOLD_NONE;
                bus_cnt_nxt = 8'd0;
                state_nxt   = RUN;
            end
        end
    end

endmodule
